// File: rtl/gray_stream_pkg.sv
// Shared types and constants for the gray pixel stream source.
// Frame states, counter width and the value driven on blank or underrun pixels.
package gray_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    localparam int CNT_W = 11;

    localparam logic [7:0] BLANK_PIX = 8'd0;

endpackage

// File: rtl/gray_stream_timing_counter.sv
// Frame timing generator: state register plus horizontal and line counters.
// Vertical regions with a line count of zero are skipped entirely.
module gray_stream_timing_counter
    import gray_stream_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 2,
    parameter int V_BACK    = 33,
    parameter int V_FRONT   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    output state_t           o_state,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_last_cycle_of_frame
);

    localparam int H_TOTAL = IMG_HDISP + H_BLANK;

    generate
        if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_bad_htotal
            $error("IMG_HDISP + H_BLANK must be in 1..2048");
        end
        if (IMG_VDISP < 1 || IMG_VDISP > 2048 || VS_LINES > 2048 ||
            V_BACK > 2048 || V_FRONT > 2048) begin : g_bad_lines
            $error("line counts must fit the line counter and IMG_VDISP must be nonzero");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    state_t           w_state_next;
    state_t           w_succ;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_line_end;
    logic             w_last;

    function automatic logic [CNT_W-1:0] lines_of(input state_t s);
        case (s)
            ST_VSYNC:  return CNT_W'(VS_LINES);
            ST_VBACK:  return CNT_W'(V_BACK);
            ST_ACTIVE: return CNT_W'(IMG_VDISP);
            ST_VFRONT: return CNT_W'(V_FRONT);
            default:   return '0;
        endcase
    endfunction

    // First non-empty region at or after s; ST_IDLE stands for "frame over".
    function automatic state_t first_from(input state_t s);
        case (s)
            ST_VSYNC:  return (VS_LINES > 0) ? ST_VSYNC : ((V_BACK > 0) ? ST_VBACK : ST_ACTIVE);
            ST_VBACK:  return (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
            ST_ACTIVE: return ST_ACTIVE;
            ST_VFRONT: return (V_FRONT > 0) ? ST_VFRONT : ST_IDLE;
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic state_t successor(input state_t s);
        case (s)
            ST_VSYNC:  return first_from(ST_VBACK);
            ST_VBACK:  return ST_ACTIVE;
            ST_ACTIVE: return first_from(ST_VFRONT);
            default:   return ST_IDLE;
        endcase
    endfunction

    assign w_line_end = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_succ     = successor(r_state);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_h_next     = r_h_cnt;
        w_v_next     = r_v_cnt;
        w_last       = 1'b0;
        if (r_state == ST_IDLE) begin
            if (i_enable) begin
                w_state_next = first_from(ST_VSYNC);
                w_h_next     = '0;
                w_v_next     = '0;
            end
        end else if (w_line_end) begin
            w_h_next = '0;
            if (r_v_cnt == lines_of(r_state) - 1'b1) begin
                w_v_next = '0;
                if (w_succ == ST_IDLE) begin
                    w_last       = 1'b1;
                    w_state_next = i_enable ? first_from(ST_VSYNC) : ST_IDLE;
                end else begin
                    w_state_next = w_succ;
                end
            end else begin
                w_v_next = r_v_cnt + 1'b1;
            end
        end else begin
            w_h_next = r_h_cnt + 1'b1;
        end
    end

    assign o_state               = r_state;
    assign o_h_cnt               = r_h_cnt;
    assign o_v_cnt               = r_v_cnt;
    assign o_last_cycle_of_frame = w_last;

endmodule

// File: rtl/gray_stream_source.sv
// Gray pixel transmitter: pulls pixels over valid/ready and emits vsync/href/Gray
// with programmable frame timing, flagging underruns and misplaced start-of-frame marks.
module gray_stream_source
    import gray_stream_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 2,
    parameter int V_BACK    = 33,
    parameter int V_FRONT   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       s_pix_valid,
    input  logic [7:0] s_pix_data,
    input  logic       s_pix_sof,
    output logic       s_pix_ready,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic [7:0] per_img_Gray,
    output logic       frame_done,
    output logic       underrun,
    output logic       sof_err,
    input  logic       clr_status
);

    state_t           w_state;
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_first_pix;
    logic             w_underrun_set;
    logic             w_sof_set;

    logic             r_vsync;
    logic             r_href;
    logic [7:0]       r_gray;
    logic             r_done;
    logic             r_underrun;
    logic             r_sof_err;

    gray_stream_timing_counter #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .H_BLANK   (H_BLANK),
        .VS_LINES  (VS_LINES),
        .V_BACK    (V_BACK),
        .V_FRONT   (V_FRONT)
    ) u_timing (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_enable              (enable),
        .o_state               (w_state),
        .o_h_cnt               (w_h_cnt),
        .o_v_cnt               (w_v_cnt),
        .o_last_cycle_of_frame (w_last)
    );

    assign w_ready        = (w_state == ST_ACTIVE) && (w_h_cnt < CNT_W'(IMG_HDISP));
    assign w_accept       = w_ready && s_pix_valid;
    assign w_first_pix    = (w_v_cnt == '0) && (w_h_cnt == '0);
    assign w_underrun_set = w_ready && !s_pix_valid;
    // Only the very first active pixel may carry sof; anywhere else it is an error.
    assign w_sof_set      = w_accept && (w_first_pix ? !s_pix_sof : s_pix_sof);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync    <= 1'b0;
            r_href     <= 1'b0;
            r_gray     <= BLANK_PIX;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_sof_err  <= 1'b0;
        end else begin
            r_vsync    <= (w_state == ST_VSYNC);
            r_href     <= w_ready;
            r_gray     <= w_accept ? s_pix_data : BLANK_PIX;
            r_done     <= w_last;
            r_underrun <= w_underrun_set | (r_underrun & ~clr_status);
            r_sof_err  <= w_sof_set | (r_sof_err & ~clr_status);
        end
    end

    assign s_pix_ready     = w_ready;
    assign per_frame_vsync = r_vsync;
    assign per_frame_href  = r_href;
    assign per_img_Gray    = r_gray;
    assign frame_done      = r_done;
    assign underrun        = r_underrun;
    assign sof_err         = r_sof_err;

endmodule

// File: tb/tb_gray_stream_source.sv
// Directed bench for gray_stream_source with a small frame (8x4 active, 12-clock lines, 84-clock frames).
module tb_gray_stream_source;

    localparam int FRAME = 84;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       s_pix_valid;
    logic [7:0] s_pix_data;
    logic       s_pix_sof;
    logic       s_pix_ready;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic [7:0] per_img_Gray;
    logic       frame_done;
    logic       underrun;
    logic       sof_err;
    logic       clr_status;

    int vectors    = 0;
    int miscompares = 0;
    int pix_idx    = 0;
    bit sof_auto   = 1'b1;

    gray_stream_source #(
        .IMG_HDISP (8),
        .IMG_VDISP (4),
        .H_BLANK   (4),
        .VS_LINES  (1),
        .V_BACK    (1),
        .V_FRONT   (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .s_pix_valid     (s_pix_valid),
        .s_pix_data      (s_pix_data),
        .s_pix_sof       (s_pix_sof),
        .s_pix_ready     (s_pix_ready),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_img_Gray    (per_img_Gray),
        .frame_done      (frame_done),
        .underrun        (underrun),
        .sof_err         (sof_err),
        .clr_status      (clr_status)
    );

    always #5 clk = ~clk;

    // Frame-relative model: VSYNC 0..11, VBACK 12..23, ACTIVE 24..71, VFRONT 72..83.
    function automatic bit m_ready(int ft);
        return (ft >= 24) && (ft < 72) && (((ft - 24) % 12) < 8);
    endfunction

    function automatic int m_pix(int ft);
        return ((ft - 24) / 12) * 8 + ((ft - 24) % 12);
    endfunction

    // One clock; the ramp source advances only on an accepted pixel.
    task automatic tick();
        bit acc;
        acc = s_pix_ready && s_pix_valid;
        @(posedge clk);
        #1;
        if (acc) pix_idx++;
        s_pix_data = pix_idx[7:0];
        if (sof_auto) s_pix_sof = ((pix_idx % 32) == 0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        clr_status  = 1'b0;
        s_pix_valid = 1'b1;
        sof_auto    = 1'b1;
        tick();
        tick();
        rst_n      = 1'b1;
        pix_idx    = 0;
        s_pix_data = 8'd0;
        s_pix_sof  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 7;
        if (per_frame_vsync !== 1'b0) begin miscompares++; $display("FAIL reset_vsync got=%b exp=0", per_frame_vsync); end
        if (per_frame_href !== 1'b0) begin miscompares++; $display("FAIL reset_href got=%b exp=0", per_frame_href); end
        if (per_img_Gray !== 8'd0) begin miscompares++; $display("FAIL reset_gray got=%0d exp=0", per_img_Gray); end
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        if (sof_err !== 1'b0) begin miscompares++; $display("FAIL reset_sof_err got=%b exp=0", sof_err); end
        if (s_pix_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", s_pix_ready); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_frames();
        bit         prev_ready;
        int         rdy_cnt;
        int         ft_o;
        int         f;
        bit         e_vs;
        bit         e_href;
        logic [7:0] e_gray;
        bit         e_done;
        do_reset();
        enable = 1'b1;
        tick();
        vectors += 2;
        if (per_frame_vsync !== 1'b0) begin miscompares++; $display("FAIL frames_vsync_c0 got=%b exp=0", per_frame_vsync); end
        if (s_pix_ready !== 1'b0) begin miscompares++; $display("FAIL frames_ready_c0 got=%b exp=0", s_pix_ready); end
        prev_ready = s_pix_ready;
        rdy_cnt    = 0;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            tick();
            ft_o   = (c - 1) % FRAME;
            f      = (c - 1) / FRAME;
            e_vs   = (ft_o < 12);
            e_href = m_ready(ft_o);
            e_gray = e_href ? 8'(f * 32 + m_pix(ft_o)) : 8'd0;
            e_done = ((c % FRAME) == 0);
            vectors += 6;
            if (per_frame_vsync !== e_vs) begin miscompares++; $display("FAIL frames_vsync c=%0d got=%b exp=%b", c, per_frame_vsync, e_vs); end
            if (per_frame_href !== e_href) begin miscompares++; $display("FAIL frames_href c=%0d got=%b exp=%b", c, per_frame_href, e_href); end
            if (per_img_Gray !== e_gray) begin miscompares++; $display("FAIL frames_gray c=%0d got=%0d exp=%0d", c, per_img_Gray, e_gray); end
            if (frame_done !== e_done) begin miscompares++; $display("FAIL frames_done c=%0d got=%b exp=%b", c, frame_done, e_done); end
            if (per_frame_href !== prev_ready) begin miscompares++; $display("FAIL href_vs_ready c=%0d got=%b exp=%b", c, per_frame_href, prev_ready); end
            if (s_pix_ready !== m_ready(c % FRAME)) begin miscompares++; $display("FAIL frames_ready c=%0d got=%b exp=%b", c, s_pix_ready, m_ready(c % FRAME)); end
            prev_ready = s_pix_ready;
            if (s_pix_ready === 1'b1) rdy_cnt++;
            if ((c % FRAME) == 0) begin
                vectors++;
                if (rdy_cnt != 32) begin miscompares++; $display("FAIL ready_count c=%0d got=%0d exp=32", c, rdy_cnt); end
                rdy_cnt = 0;
            end
        end
        vectors += 2;
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL frames_underrun got=%b exp=0", underrun); end
        if (sof_err !== 1'b0) begin miscompares++; $display("FAIL frames_sof_err got=%b exp=0", sof_err); end
        $display("test_frames: two back-to-back frames checked");
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        tick();
        for (int c = 1; c <= 120; c++) begin
            if (c == 40) enable = 1'b0;
            tick();
            vectors++;
            if (frame_done !== (c == FRAME)) begin miscompares++; $display("FAIL drop_done c=%0d got=%b exp=%b", c, frame_done, (c == FRAME)); end
            if (c <= FRAME) begin
                vectors++;
                if (per_frame_href !== m_ready(c - 1)) begin miscompares++; $display("FAIL drop_href c=%0d got=%b exp=%b", c, per_frame_href, m_ready(c - 1)); end
            end else begin
                vectors += 3;
                if (per_frame_vsync !== 1'b0) begin miscompares++; $display("FAIL drop_idle_vsync c=%0d got=%b exp=0", c, per_frame_vsync); end
                if (per_frame_href !== 1'b0) begin miscompares++; $display("FAIL drop_idle_href c=%0d got=%b exp=0", c, per_frame_href); end
                if (per_img_Gray !== 8'd0) begin miscompares++; $display("FAIL drop_idle_gray c=%0d got=%0d exp=0", c, per_img_Gray); end
            end
            if (c >= FRAME) begin
                vectors++;
                if (s_pix_ready !== 1'b0) begin miscompares++; $display("FAIL drop_idle_ready c=%0d got=%b exp=0", c, s_pix_ready); end
            end
        end
        $display("test_enable_drop: frame completed then idle");
    endtask

    task automatic test_underrun();
        bit e_ur;
        do_reset();
        enable = 1'b1;
        tick();
        for (int c = 1; c <= 50; c++) begin
            s_pix_valid = (c != 40);
            clr_status  = (c == 47);
            tick();
            e_ur = (c >= 40) && (c <= 46);
            vectors++;
            if (underrun !== e_ur) begin miscompares++; $display("FAIL underrun_flag c=%0d got=%b exp=%b", c, underrun, e_ur); end
            if (c == 39 || c == 40 || c == 41 || c == 42) begin
                vectors += 2;
                if (per_frame_href !== 1'b1) begin miscompares++; $display("FAIL underrun_href c=%0d got=%b exp=1", c, per_frame_href); end
                case (c)
                    39: if (per_img_Gray !== 8'd10) begin miscompares++; $display("FAIL underrun_gray c=%0d got=%0d exp=10", c, per_img_Gray); end
                    40: if (per_img_Gray !== 8'd0) begin miscompares++; $display("FAIL underrun_gray c=%0d got=%0d exp=0", c, per_img_Gray); end
                    41: if (per_img_Gray !== 8'd11) begin miscompares++; $display("FAIL underrun_gray c=%0d got=%0d exp=11", c, per_img_Gray); end
                    default: if (per_img_Gray !== 8'd12) begin miscompares++; $display("FAIL underrun_gray c=%0d got=%0d exp=12", c, per_img_Gray); end
                endcase
            end
        end
        s_pix_valid = 1'b1;
        clr_status  = 1'b0;
        vectors++;
        if (sof_err !== 1'b0) begin miscompares++; $display("FAIL underrun_sof_err got=%b exp=0", sof_err); end
        $display("test_underrun: missing pixel, flag and clear checked");
    endtask

    task automatic test_sof();
        bit e_se;
        do_reset();
        sof_auto  = 1'b0;
        s_pix_sof = 1'b0;
        enable    = 1'b1;
        tick();
        for (int c = 1; c <= 32; c++) begin
            clr_status = (c == 27) || (c == 29) || (c == 31);
            s_pix_sof  = (c == 29);
            tick();
            e_se = ((c >= 25) && (c <= 26)) || ((c >= 29) && (c <= 30));
            vectors++;
            if (sof_err !== e_se) begin miscompares++; $display("FAIL sof_err_flag c=%0d got=%b exp=%b", c, sof_err, e_se); end
        end
        clr_status = 1'b0;
        s_pix_sof  = 1'b0;
        sof_auto   = 1'b1;
        vectors++;
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL sof_underrun got=%b exp=0", underrun); end
        $display("test_sof: missing and stray sof, clear priority checked");
    endtask

    task automatic test_reset_mid();
        bit e_vs;
        do_reset();
        enable = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            s_pix_valid = (c != 27);
            tick();
        end
        s_pix_valid = 1'b1;
        vectors += 2;
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL mid_pre_underrun got=%b exp=1", underrun); end
        if (per_frame_href !== 1'b1) begin miscompares++; $display("FAIL mid_pre_href got=%b exp=1", per_frame_href); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors += 7;
        if (per_frame_vsync !== 1'b0) begin miscompares++; $display("FAIL mid_vsync got=%b exp=0", per_frame_vsync); end
        if (per_frame_href !== 1'b0) begin miscompares++; $display("FAIL mid_href got=%b exp=0", per_frame_href); end
        if (per_img_Gray !== 8'd0) begin miscompares++; $display("FAIL mid_gray got=%0d exp=0", per_img_Gray); end
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL mid_done got=%b exp=0", frame_done); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL mid_underrun got=%b exp=0", underrun); end
        if (sof_err !== 1'b0) begin miscompares++; $display("FAIL mid_sof_err got=%b exp=0", sof_err); end
        if (s_pix_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready got=%b exp=0", s_pix_ready); end
        pix_idx    = 0;
        s_pix_data = 8'd0;
        s_pix_sof  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            e_vs = (k >= 2) && (k <= 13);
            vectors += 2;
            if (per_frame_vsync !== e_vs) begin miscompares++; $display("FAIL mid_restart_vsync k=%0d got=%b exp=%b", k, per_frame_vsync, e_vs); end
            if (frame_done !== 1'b0) begin miscompares++; $display("FAIL mid_restart_done k=%0d got=%b exp=0", k, frame_done); end
        end
        $display("test_reset_mid: abandoned frame and restart checked");
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        s_pix_valid = 1'b0;
        s_pix_data  = 8'd0;
        s_pix_sof   = 1'b0;
        clr_status  = 1'b0;
        test_reset();
        test_frames();
        test_enable_drop();
        test_underrun();
        test_sof();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
